reg_file_sb: RTL and testbench

Parametrised register file for the CARP core, extending the integer register file with a configurable number of read ports, write-to-read bypass, synchronous clear, and a per-register scoreboard of pending writes. Decode reserves a destination register; writeback writes it and clears the reservation. Read ports report data and busy status together so the hazard unit can stall without a separate table. The block sits between decode (reads, reservations) and writeback (writes).

---
 rtl/reg_file_sb.sv | 124 ++++++++++++
 tb/tb_reg_file_sb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with NRD combinational read ports,
// optional write-to-read bypass, hardwired-zero register 0, and a
// per-register scoreboard of pending writes with a registered pending count.
//
// Ports
//   clk_i       clock, all state updates on the rising edge
//   rst_i       synchronous active-high reset: data, busy bits and count -> 0
//   rd_addr_i   NRD read addresses, port k at [k*AW +: AW]
//   rd_data_o   NRD read data words, port k at [k*XLEN +: XLEN]
//   rd_busy_o   NRD busy flags, port k register has a pending write
//   wr_en_i     write strobe (writeback); clears the register's busy bit
//   wr_addr_i   write address
//   wr_data_i   write data
//   res_en_i    reserve strobe (decode); sets the register's busy bit
//   res_addr_i  register to reserve
//   flush_i     clears every busy bit and the count; data is untouched
//   pend_cnt_o  number of registers currently pending (registered)
//
// Strobe semantics: wr_en_i, res_en_i and flush_i are single-cycle
// qualifiers sampled at the rising edge; there is no back-pressure, every
// strobe present at an edge (outside reset) takes effect at that edge.
module reg_file_sb #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]    rd_busy_o,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [XLEN-1:0]   wr_data_i,
  input  logic              res_en_i,
  input  logic [AW-1:0]     res_addr_i,
  input  logic              flush_i,
  output logic [AW:0]       pend_cnt_o
);

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [XLEN-1:0]  data_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [AW:0]      cnt_q;

  logic wr_ok;
  logic res_ok;
  logic cnt_inc;
  logic cnt_dec;

  // Register 0 is not a legal target when it is hardwired to zero.
  assign wr_ok  = wr_en_i  && !((ZERO_REG != 0) && (wr_addr_i  == '0));
  assign res_ok = res_en_i && !((ZERO_REG != 0) && (res_addr_i == '0));

  // The count tracks bit transitions, not strobes: a reserve only counts if
  // it sets a clear bit, and a write only counts if it clears a set bit that
  // is not being re-reserved in the same cycle (reserve wins).
  assign cnt_inc = res_ok && !busy_q[res_addr_i];
  assign cnt_dec = wr_ok && busy_q[wr_addr_i] &&
                   !(res_ok && (res_addr_i == wr_addr_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        data_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) begin
        data_q[wr_addr_i] <= wr_data_i;
      end
      if (flush_i) begin
        busy_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (wr_ok) begin
          busy_q[wr_addr_i] <= 1'b0;
        end
        // Placed after the write clear so a same-register reserve wins.
        if (res_ok) begin
          busy_q[res_addr_i] <= 1'b1;
        end
        case ({cnt_inc, cnt_dec})
          2'b10:   cnt_q <= cnt_q + CNT_ONE;
          2'b01:   cnt_q <= cnt_q - CNT_ONE;
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  assign pend_cnt_o = cnt_q;

  // Read ports: zero register first, then the same-cycle write, then storage.
  // Reservations and flush are deliberately not forwarded.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr_i[k*AW +: AW];

    always_comb begin
      data = data_q[addr];
      busy = busy_q[addr];
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end else if ((BYPASS != 0) && wr_ok && (wr_addr_i == addr)) begin
        data = wr_data_i;
        busy = 1'b0;
      end
    end

    assign rd_data_o[k*XLEN +: XLEN] = data;
    assign rd_busy_o[k]              = busy;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb with default parameters (XLEN=32, NREGS=32,
// NRD=2, ZERO_REG=1, BYPASS=1). Inputs change on the falling edge, outputs
// are sampled 1 time unit later; the reference model advances at each
// rising edge from the inputs that were presented.
module tb_reg_file_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic              res_en;
  logic [AW-1:0]     res_addr;
  logic              flush;
  logic [AW:0]       pend_cnt;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .res_en_i(res_en), .res_addr_i(res_addr),
    .flush_i(flush), .pend_cnt_o(pend_cnt)
  );

  // ---------------- reference model ----------------
  // Architectural view: a value per register and a pending flag per
  // register; the pending count is simply how many flags are set.
  logic [XLEN-1:0] m_data [NREGS];
  logic            m_busy [NREGS];

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_data[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (wr_en && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [AW:0] exp_cnt();
    int s = 0;
    for (int i = 0; i < NREGS; i++) s += int'(m_busy[i]);
    return (AW+1)'(s);
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_data[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_data[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (res_en && res_addr != 0) m_busy[res_addr] = 1'b1;
      if (flush) begin
        for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    res_en = 1'b0; res_addr = '0; flush = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ports(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr[0 +: AW]  = a0;
    rd_addr[AW +: AW] = a1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; idle(); ports('0, '0);
    cycle();
    rst = 1'b0;
    for (int a = 0; a < NREGS; a++) begin
      ports(AW'(a), AW'(NREGS-1-a));
      #1;
      n_cmp++; if (rd_data[0 +: XLEN] !== '0) begin n_err++; $display("FAIL reset_data0 a=%0d: got %h exp 0", a, rd_data[0 +: XLEN]); end
      n_cmp++; if (rd_data[XLEN +: XLEN] !== '0) begin n_err++; $display("FAIL reset_data1 a=%0d: got %h exp 0", a, rd_data[XLEN +: XLEN]); end
      n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL reset_busy a=%0d: got %b exp 00", a, rd_busy); end
      cycle();
    end
    n_cmp++; if (pend_cnt !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d exp 0", pend_cnt); end
  endtask

  task automatic test_bypass_write();
    idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    ports(5'd5, 5'd6);
    #1;
    n_cmp++; if (rd_data[0 +: XLEN] !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_same_cycle: got %h exp deadbeef", rd_data[0 +: XLEN]); end
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL bypass_busy: got %b exp 0", rd_busy[0]); end
    cycle();
    idle(); ports(5'd5, 5'd5);
    #1;
    n_cmp++; if (rd_data[0 +: XLEN] !== 32'hDEADBEEF) begin n_err++; $display("FAIL stored_port0: got %h exp deadbeef", rd_data[0 +: XLEN]); end
    n_cmp++; if (rd_data[XLEN +: XLEN] !== 32'hDEADBEEF) begin n_err++; $display("FAIL stored_port1: got %h exp deadbeef", rd_data[XLEN +: XLEN]); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL stored_busy: got %b exp 00", rd_busy); end
  endtask

  task automatic test_zero_reg();
    idle();
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'h1234;
    res_en = 1'b1; res_addr = '0;
    ports('0, '0);
    #1;
    n_cmp++; if (rd_data[0 +: XLEN] !== '0) begin n_err++; $display("FAIL x0_no_bypass: got %h exp 0", rd_data[0 +: XLEN]); end
    cycle();
    idle();
    #1;
    n_cmp++; if (rd_data[XLEN +: XLEN] !== '0) begin n_err++; $display("FAIL x0_data: got %h exp 0", rd_data[XLEN +: XLEN]); end
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL x0_busy: got %b exp 00", rd_busy); end
    n_cmp++; if (pend_cnt !== '0) begin n_err++; $display("FAIL x0_cnt: got %0d exp 0", pend_cnt); end
  endtask

  task automatic test_reserve_write();
    idle(); res_en = 1'b1; res_addr = 5'd3; ports(5'd3, 5'd3);
    #1;
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL res_not_bypassed: got %b exp 0", rd_busy[0]); end
    cycle();
    idle();
    #1;
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL res_busy: got %b exp 1", rd_busy[0]); end
    n_cmp++; if (pend_cnt !== 6'd1) begin n_err++; $display("FAIL res_cnt: got %0d exp 1", pend_cnt); end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd7;
    #1;
    n_cmp++; if (rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL wr_busy_bypass: got %b exp 0", rd_busy[0]); end
    n_cmp++; if (rd_data[0 +: XLEN] !== 32'd7) begin n_err++; $display("FAIL wr_data_bypass: got %h exp 7", rd_data[0 +: XLEN]); end
    n_cmp++; if (pend_cnt !== 6'd1) begin n_err++; $display("FAIL wr_cnt_before_edge: got %0d exp 1", pend_cnt); end
    cycle();
    idle();
    #1;
    n_cmp++; if (pend_cnt !== '0) begin n_err++; $display("FAIL wr_cnt_after: got %0d exp 0", pend_cnt); end
    n_cmp++; if (rd_busy[1] !== 1'b0 || rd_data[XLEN +: XLEN] !== 32'd7) begin n_err++; $display("FAIL wr_after: got busy %b data %h exp busy 0 data 7", rd_busy[1], rd_data[XLEN +: XLEN]); end
  endtask

  task automatic test_write_reserve_same();
    idle();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd9;
    res_en = 1'b1; res_addr = 5'd4;
    cycle();
    idle(); ports(5'd4, 5'd4);
    #1;
    n_cmp++; if (rd_data[0 +: XLEN] !== 32'd9) begin n_err++; $display("FAIL wr_res_data: got %h exp 9", rd_data[0 +: XLEN]); end
    n_cmp++; if (rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL wr_res_busy: got %b exp 1", rd_busy[0]); end
    n_cmp++; if (pend_cnt !== 6'd1) begin n_err++; $display("FAIL wr_res_cnt: got %0d exp 1", pend_cnt); end
  endtask

  task automatic test_flush();
    // x4 is still pending from the previous test.
    for (int r = 1; r <= 3; r++) begin
      idle(); res_en = 1'b1; res_addr = AW'(r);
      cycle();
    end
    idle(); ports(5'd2, 5'd4);
    #1;
    n_cmp++; if (pend_cnt !== 6'd4) begin n_err++; $display("FAIL pre_flush_cnt: got %0d exp 4", pend_cnt); end
    n_cmp++; if (rd_busy !== 2'b11) begin n_err++; $display("FAIL pre_flush_busy: got %b exp 11", rd_busy); end
    flush = 1'b1; res_en = 1'b1; res_addr = 5'd6;
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h55;
    cycle();
    idle(); ports(5'd1, 5'd2);
    #1;
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL flush_busy_1_2: got %b exp 00", rd_busy); end
    n_cmp++; if (rd_data[XLEN +: XLEN] !== 32'h55) begin n_err++; $display("FAIL flush_x2_data: got %h exp 55", rd_data[XLEN +: XLEN]); end
    ports(5'd3, 5'd6);
    #1;
    n_cmp++; if (rd_busy !== 2'b00) begin n_err++; $display("FAIL flush_busy_3_6: got %b exp 00", rd_busy); end
    n_cmp++; if (pend_cnt !== '0) begin n_err++; $display("FAIL flush_cnt: got %0d exp 0", pend_cnt); end
  endtask

  task automatic test_reset_mid();
    idle(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hAA;
    cycle();
    idle(); res_en = 1'b1; res_addr = 5'd8;
    cycle();
    idle(); ports(5'd7, 5'd8);
    #1;
    n_cmp++; if (rd_data[0 +: XLEN] !== 32'hAA || rd_busy[1] !== 1'b1) begin n_err++; $display("FAIL pre_reset: got x7 %h x8busy %b exp aa 1", rd_data[0 +: XLEN], rd_busy[1]); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    n_cmp++; if (rd_data[0 +: XLEN] !== '0) begin n_err++; $display("FAIL mid_reset_x7: got %h exp 0", rd_data[0 +: XLEN]); end
    n_cmp++; if (rd_busy[1] !== 1'b0) begin n_err++; $display("FAIL mid_reset_x8_busy: got %b exp 0", rd_busy[1]); end
    n_cmp++; if (pend_cnt !== '0) begin n_err++; $display("FAIL mid_reset_cnt: got %0d exp 0", pend_cnt); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int it = 0; it < 600; it++) begin
      rst      = ($urandom_range(0, 79) == 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      res_en   = 1'($urandom_range(0, 1));
      res_addr = AW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 24) == 0);
      ports(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 9)));
      #1;
      for (int p = 0; p < NRD; p++) begin
        a = rd_addr[p*AW +: AW];
        n_cmp++; if (rd_data[p*XLEN +: XLEN] !== exp_data(a)) begin n_err++; $display("FAIL rand_data it=%0d port=%0d addr=%0d: got %h exp %h", it, p, a, rd_data[p*XLEN +: XLEN], exp_data(a)); end
        n_cmp++; if (rd_busy[p] !== exp_busy(a)) begin n_err++; $display("FAIL rand_busy it=%0d port=%0d addr=%0d: got %b exp %b", it, p, a, rd_busy[p], exp_busy(a)); end
      end
      n_cmp++; if (pend_cnt !== exp_cnt()) begin n_err++; $display("FAIL rand_cnt it=%0d: got %0d exp %0d", it, pend_cnt, exp_cnt()); end
      cycle();
    end
    rst = 1'b0; idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; idle(); ports('0, '0);
    for (int i = 0; i < NREGS; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_bypass_write();
    test_zero_reg();
    test_reserve_write();
    test_write_reserve_same();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
